// File: rtl/store_pkg.sv
// Shared definitions for the memory-stage store path: size codes (common with
// the load-side extension unit), store FSM state encoding and byte-enable masks.
package store_pkg;

  // Access size codes
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Store sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Byte-enable patterns for a right-justified operand, before lane shifting
  localparam logic [3:0] BASE_BYTE = 4'b0001;
  localparam logic [3:0] BASE_HALF = 4'b0011;
  localparam logic [3:0] BASE_WORD = 4'b1111;
  localparam logic [3:0] BASE_NONE = 4'b0000;

  // Byte-enable pattern for a size code; reserved sizes enable nothing
  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return BASE_BYTE;
      SZ_HALF: return BASE_HALF;
      SZ_WORD: return BASE_WORD;
      default: return BASE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane steering: moves a right-justified store operand into its
// byte lanes across a two-word window and produces the matching 8-bit mask.
// Bytes above the access size are zeroed so unused lanes are always 0.
module store_lane_shift
  import store_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  output logic [63:0] shifted,
  output logic [7:0]  mask
);

  logic [3:0]  base;
  logic [31:0] kept;

  // Trim the operand to its size, then shift data and mask by the byte offset
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    base    = base_mask(size);
    kept    = data & {{8{base[3]}}, {8{base[2]}}, {8{base[1]}}, {8{base[0]}}};
    shifted = {32'b0, kept} << {off, 3'b000};
    mask    = {4'b0000, base} << off;
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts a store from execute, steers it into byte lanes,
// and writes it to word-organised memory in one or two request/ack beats, with
// a per-beat acknowledge timeout.
// Build option: define STORE_MISALIGN_SPLIT_EN to split word-crossing and
// misaligned stores into two beats; when undefined such stores fault with no beat.
module store_align_unit
  import store_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_fault
);

  localparam int               CNT_W     = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT - 1);

  state_t            state;
  logic [63:0]       shifted;
  logic [7:0]        mask;
  logic [ADDR_W-1:0] lo_addr;
  logic              has_hi;
  logic              reject;

  logic [ADDR_W-1:0] hi_addr_q;
  logic [31:0]       hi_wdata_q;
  logic [3:0]        hi_be_q;
  logic              has_hi_q;
  logic [CNT_W-1:0]  wait_cnt;

  store_lane_shift u_lane_shift (
    .data    (st_data),
    .size    (st_size),
    .off     (st_addr[1:0]),
    .shifted (shifted),
    .mask    (mask)
  );

  assign lo_addr = {st_addr[ADDR_W-1:2], 2'b00};
  assign has_hi  = |mask[7:4];

`ifdef STORE_MISALIGN_SPLIT_EN
  assign reject = (st_size == SZ_RSVD);
`else
  logic misaligned;

  // Natural alignment: halves on even bytes, words on word boundaries
  always_comb begin
    misaligned = 1'b0;
    case (st_size)
      SZ_HALF: misaligned = st_addr[0];
      SZ_WORD: misaligned = |st_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign reject = (st_size == SZ_RSVD) || has_hi || misaligned;
`endif

  // Store sequencer: accept, drive lo/hi beats until acked or timed out, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      st_ready   <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      st_done    <= 1'b0;
      st_fault   <= 1'b0;
      wait_cnt   <= '0;
      hi_addr_q  <= '0;
      hi_wdata_q <= '0;
      hi_be_q    <= '0;
      has_hi_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      st_done  <= 1'b0;
      st_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid) begin
            hi_addr_q  <= lo_addr + ADDR_W'(4);
            hi_wdata_q <= shifted[63:32];
            hi_be_q    <= mask[7:4];
            has_hi_q   <= has_hi;
            wait_cnt   <= '0;
            st_ready   <= 1'b0;
            if (reject) begin
              state    <= RESP;
              st_done  <= 1'b1;
              st_fault <= 1'b1;
            end else begin
              state     <= WR_LO;
              mem_req   <= 1'b1;
              mem_addr  <= lo_addr;
              mem_wdata <= shifted[31:0];
              mem_be    <= mask[3:0];
            end
          end
        end
        WR_LO, WR_HI: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            if (state == WR_LO && has_hi_q) begin
              state     <= WR_HI;
              mem_addr  <= hi_addr_q;
              mem_wdata <= hi_wdata_q;
              mem_be    <= hi_be_q;
            end else begin
              state     <= RESP;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_be    <= '0;
              st_done   <= 1'b1;
            end
          end else if (wait_cnt == CNT_LIMIT) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            st_done   <= 1'b1;
            st_fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state    <= IDLE;
          st_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit: directed stores from the test plan,
// timeout and reset scenarios, and randomized stores checked against a
// byte-by-byte reference model of the memory writes.
module tb_store_align_unit;

  localparam int ADDR_W = 32;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic              st_done;
  logic              st_fault;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_align_unit #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .st_done   (st_done),
    .st_fault  (st_fault)
  );

  // Reference model results
  int          exp_nb;
  int          exp_started;
  int          exp_done_cyc;
  int          exp_req_cyc;
  bit          exp_fault;
  logic [31:0] exp_addr[2];
  logic [3:0]  exp_be[2];
  logic [31:0] exp_wd[2];

  // Observed results
  int          obs_nb;
  int          obs_done_cyc;
  int          obs_req_cyc;
  bit          obs_fault;
  bit          obs_done;
  bit          obs_stable;
  bit          obs_stray;
  logic [31:0] obs_addr[4];
  logic [3:0]  obs_be[4];
  logic [31:0] obs_wd[4];

  // Model: each operand byte lands at byte address addr+i; bytes sharing a
  // word form one write. Timing: accept is cycle 1, each beat lasts delay+1
  // cycles (or TO cycles if the ack never comes), done follows the last beat.
  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [1:0] size, input int d0, input int d1);
    int          nbytes;
    int          dly[2];
    int          lane;
    logic [31:0] a;
    logic [31:0] w;
    dly[0] = d0;
    dly[1] = d1;
    exp_nb = 0; exp_started = 0; exp_fault = 1'b0; exp_req_cyc = 0; exp_done_cyc = 2;
    for (int b = 0; b < 2; b++) begin
      exp_addr[b] = '0; exp_be[b] = '0; exp_wd[b] = '0;
    end
    case (size)
      2'd0:    nbytes = 1;
      2'd1:    nbytes = 2;
      2'd2:    nbytes = 4;
      default: nbytes = 0;
    endcase
    if (nbytes == 0) begin
      exp_fault = 1'b1;
      return;
    end
`ifndef STORE_MISALIGN_SPLIT_EN
    if ((addr % 32'(nbytes)) != 0) begin
      exp_fault = 1'b1;
      return;
    end
`endif
    for (int i = 0; i < nbytes; i++) begin
      a    = addr + 32'(i);
      w    = a & ~32'd3;
      lane = int'(a[1:0]);
      if (exp_nb == 0 || w != exp_addr[exp_nb-1]) begin
        exp_addr[exp_nb] = w;
        exp_be[exp_nb]   = '0;
        exp_wd[exp_nb]   = '0;
        exp_nb++;
      end
      exp_be[exp_nb-1][lane]       = 1'b1;
      exp_wd[exp_nb-1][8*lane +: 8] = data[8*i +: 8];
    end
    for (int b = 0; b < exp_nb; b++) begin
      exp_started++;
      if (dly[b] >= TO) begin
        exp_req_cyc  += TO;
        exp_done_cyc += TO;
        exp_fault     = 1'b1;
        break;
      end
      exp_req_cyc  += dly[b] + 1;
      exp_done_cyc += dly[b] + 1;
    end
  endfunction

  // One store: drive it, answer each beat after its delay, compare with the model
  task automatic test_one_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input int d0, input int d1, input bit noise);
    int dly[2];
    int k;
    int idx;
    int cyc;
    bit in_beat;
    dly[0] = d0;
    dly[1] = d1;
    model_store(addr, data, size, d0, d1);
    for (int i = 0; i < 50 && !st_ready; i++) @(negedge clk);
    st_valid = 1'b1; st_addr = addr; st_data = data; st_size = size;
    mem_ack  = noise ? 1'($urandom) : 1'b0;
    obs_nb = 0; obs_req_cyc = 0; obs_done = 1'b0; obs_fault = 1'b0; obs_done_cyc = -1;
    obs_stable = 1'b1; obs_stray = 1'b0; in_beat = 1'b0; k = 0; cyc = 1;
    while (!obs_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      st_valid = 1'b0; st_addr = $urandom; st_data = $urandom; st_size = 2'($urandom);
      if (st_fault && !st_done) obs_stray = 1'b1;
      if (st_done) begin
        obs_done = 1'b1; obs_fault = st_fault; obs_done_cyc = cyc; mem_ack = 1'b0;
      end else if (mem_req) begin
        obs_req_cyc++;
        if (!in_beat) begin
          if (obs_nb < 4) begin
            obs_addr[obs_nb] = mem_addr; obs_be[obs_nb] = mem_be; obs_wd[obs_nb] = mem_wdata;
          end
          obs_nb++; in_beat = 1'b1; k = 0;
        end else begin
          if (obs_nb <= 4 && (mem_addr !== obs_addr[obs_nb-1] || mem_be !== obs_be[obs_nb-1] ||
                              mem_wdata !== obs_wd[obs_nb-1]))
            obs_stable = 1'b0;
          k++;
        end
        idx = (obs_nb > 2) ? 1 : obs_nb - 1;
        if (k >= dly[idx]) begin
          mem_ack = 1'b1; in_beat = 1'b0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        in_beat = 1'b0;
        mem_ack = noise ? 1'($urandom) : 1'b0;
      end
    end
    mem_ack = 1'b0;

    vectors++;
    if (!obs_done) begin
      miscompares++;
      $display("FAIL %s done_timeout: st_done not seen within %0d cycles", name, cyc);
    end
    vectors++;
    if (obs_done_cyc != exp_done_cyc) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, obs_done_cyc, exp_done_cyc);
    end
    vectors++;
    if (obs_fault != exp_fault) begin
      miscompares++;
      $display("FAIL %s fault: got %0b want %0b", name, obs_fault, exp_fault);
    end
    vectors++;
    if (obs_nb != exp_started) begin
      miscompares++;
      $display("FAIL %s beats: got %0d want %0d", name, obs_nb, exp_started);
    end
    vectors++;
    if (obs_req_cyc != exp_req_cyc) begin
      miscompares++;
      $display("FAIL %s req_cycles: got %0d want %0d", name, obs_req_cyc, exp_req_cyc);
    end
    for (int b = 0; b < exp_started && b < obs_nb; b++) begin
      vectors++;
      if (obs_addr[b] !== exp_addr[b] || obs_be[b] !== exp_be[b] || obs_wd[b] !== exp_wd[b]) begin
        miscompares++;
        $display("FAIL %s beat%0d: got addr %h be %b wdata %h want addr %h be %b wdata %h",
                 name, b, obs_addr[b], obs_be[b], obs_wd[b], exp_addr[b], exp_be[b], exp_wd[b]);
      end
    end
    vectors++;
    if (!obs_stable || obs_stray) begin
      miscompares++;
      $display("FAIL %s hold: stable=%0b stray_fault=%0b want stable=1 stray_fault=0",
               name, obs_stable, obs_stray);
    end
    @(negedge clk);
    vectors++;
    if (st_done !== 1'b0 || st_fault !== 1'b0 || st_ready !== 1'b1 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done: got done %b fault %b ready %b req %b want 0 0 1 0",
               name, st_done, st_fault, st_ready, mem_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (st_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        mem_be !== '0 || st_done !== 1'b0 || st_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got ready %b req %b addr %h wdata %h be %b done %b fault %b",
               st_ready, mem_req, mem_addr, mem_wdata, mem_be, st_done, st_fault);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    test_one_store("byte_103",   32'h0000_0103, 32'h0000_00A5, 2'b00, 0, 0, 1'b0);
    test_one_store("half_202",   32'h0000_0202, 32'h0000_F00D, 2'b01, 0, 0, 1'b0);
    test_one_store("word_204",   32'h0000_0204, 32'hDEAD_BEEF, 2'b10, 0, 0, 1'b0);
    test_one_store("byte_dirty", 32'h0000_0101, 32'hFFFF_FF5A, 2'b00, 1, 0, 1'b0);
    test_one_store("split_301",  32'h0000_0301, 32'h1122_3344, 2'b10, 0, 0, 1'b0);
    test_one_store("half_1ff",   32'h0000_01FF, 32'h0000_BEEF, 2'b01, 2, 1, 1'b0);
    test_one_store("half_101",   32'h0000_0101, 32'h0000_CAFE, 2'b01, 0, 0, 1'b0);
    test_one_store("wrap_word",  32'hFFFF_FFFF, 32'hA1B2_C3D4, 2'b10, 0, 0, 1'b0);
    test_one_store("reserved",   32'h0000_0200, 32'h1234_5678, 2'b11, 0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    test_one_store("timeout_lo",   32'h0000_0400, 32'h0BAD_F00D, 2'b10, 1000, 0, 1'b0);
    test_one_store("ack_at_limit", 32'h0000_0404, 32'h5555_AAAA, 2'b10, TO - 1, 0, 1'b0);
    test_one_store("ack_pre_limit", 32'h0000_0408, 32'h0000_0077, 2'b00, TO - 2, 0, 1'b0);
    test_one_store("timeout_hi",   32'h0000_0502, 32'h8765_4321, 2'b10, 0, 1000, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    st_valid = 1'b1; st_data = 32'hCAFE_BABE; st_size = 2'b10;
`ifdef STORE_MISALIGN_SPLIT_EN
    st_addr = 32'h0000_0602;
`else
    st_addr = 32'h0000_0600;
`endif
    @(negedge clk);
    st_valid = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got req %b want 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || st_ready !== 1'b1 || st_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got req %b ready %b done %b want 0 1 0", mem_req, st_ready, st_done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (st_done !== 1'b0 || mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_quiet cycle %0d: got done %b req %b want 0 0", i, st_done, mem_req);
      end
    end
    test_one_store("after_reset", 32'h0000_0700, 32'h0102_0304, 2'b10, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [1:0]  size;
    int          dl[2];
    int          r;
    for (int n = 0; n < 40; n++) begin
      addr = (n % 8 == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
      size = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      for (int b = 0; b < 2; b++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       dl[b] = r % 3;
        else if (r < 8)  dl[b] = $urandom_range(3, 6);
        else if (r == 8) dl[b] = TO - 1;
        else             dl[b] = TO;
      end
      test_one_store($sformatf("rand%0d", n), addr, $urandom, size, dl[0], dl[1], 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Memory-stage store path: accepts a store request from execute (address, register data, 2-bit size code) and writes it to word-organised data memory.
- Shifts data into the correct byte lanes and generates byte enables.
- Splits stores that cross a word boundary into two word writes.
- Runs a request/acknowledge handshake with memory. It is the write-side counterpart of the load-side sign/zero extension unit and shares its size encoding.

Parameters:
- ADDR_W, 32, address width in bits (data width is fixed at 32)
- ACK_TIMEOUT, 16, maximum cycles to wait for mem_ack per beat before faulting; must be 2 or greater

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- st_valid  input  1  store request present
- st_ready  output  1  unit can accept a request
- st_addr  input  ADDR_W  byte address
- st_data  input  32  store data, right-justified
- st_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- mem_req  output  1  memory write request
- mem_addr  output  ADDR_W  word-aligned address; bits [1:0] always 0
- mem_wdata  output  32  lane-aligned write data
- mem_be  output  4  byte enables
- mem_ack  input  1  memory accepted the current beat
- st_done  output  1  one-cycle pulse when the store completes
- st_fault  output  1  one-cycle pulse, coincident with st_done, on error

Behaviour:
- Reset values: st_ready=1; mem_req, mem_addr, mem_wdata, mem_be, st_done, st_fault all 0; state IDLE; timeout counter 0.
- Reset asserted mid-operation returns to IDLE immediately and drops mem_req asynchronously. The pending store is lost and no st_done is issued.
- Acceptance: st_valid && st_ready on a rising clock edge.
  - st_ready=1 only in IDLE.
  - Address, data and size are registered on acceptance.
- Lane shift:
  - off = st_addr[1:0].
  - 64-bit shifted data = {32'b0, st_data} << (8*off).
  - Base mask: byte 0001, half 0011, word 1111. 8-bit mask = base << off.
- Beats:
  - Lo beat: mem_addr = addr & ~3, mem_be = mask[3:0], mem_wdata = shifted[31:0].
  - Hi beat exists iff mask[7:4] != 0. It uses mem_addr = (addr & ~3) + 4, mem_be = mask[7:4], mem_wdata = shifted[63:32].
  - Word address wraps modulo 2^ADDR_W.
  - Unused lanes of mem_wdata are driven 0.
- States: IDLE, WR_LO, WR_HI, RESP.
  - IDLE to WR_LO on acceptance. mem_req rises the cycle after acceptance.
  - WR_LO: mem_req=1, outputs held stable until mem_ack. On ack, go to WR_HI if a hi beat exists, else RESP.
  - WR_HI: same hold rules. On ack, go to RESP.
  - mem_req stays high back-to-back between beats; beat outputs change on the edge that samples mem_ack.
  - RESP: st_done=1 for one cycle, then IDLE. st_ready is 0 in RESP.
- Latency with immediate ack: aligned store completes in 3 cycles (accept, beat, RESP); split store in 4.
- Timeout:
  - A counter resets at each beat start and increments while mem_req && !mem_ack.
  - When it reaches ACK_TIMEOUT-1 without ack, drop mem_req, go to RESP, and raise st_fault.
  - Ack in the same cycle as the limit counts as success.
- Reserved size (11): no memory beat. IDLE to RESP with st_fault=1.
- mem_ack outside WR_LO/WR_HI is ignored.

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined: split behaviour exactly as above.
- Undefined: any store where mask[7:4] != 0, or where the address is not naturally aligned, issues no beat. It goes IDLE to RESP with st_fault=1, and WR_HI is unreachable.
- Naturally aligned stores behave identically with and without the macro.

Decomposition:
- Shared package/include store_pkg holds:
  - size localparams SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11 (shared with the load-side extension unit)
  - state encodings
  - base-mask constants
- One natural combinational sub-module, store_lane_shift: inputs data, size, off; outputs 64-bit shifted data and 8-bit mask.

Test Plan:
- Byte store, addr 0x103, data 0x000000A5, ack immediate: one beat, mem_addr 0x100, be 1000, wdata 0xA5000000; st_done in cycle 3, no fault.
- Half store, addr 0x202, data 0x0000F00D: mem_addr 0x200, be 1100, wdata 0xF00D0000. Then a word store at addr 0x204, data 0xDEADBEEF: be 1111, wdata 0xDEADBEEF.
- Split (macro defined), word store at addr 0x301, data 0x11223344:
  - beat 1: 0x300, be 1110, wdata 0x22334400
  - beat 2: 0x304, be 0001, wdata 0x00000011
  - st_done in cycle 4
- Same stimulus, macro undefined: no mem_req; st_done and st_fault pulse together. Also size 11: fault with no beat.
- Timeout: ACK_TIMEOUT=16, mem_ack held 0: mem_req drops after 16 cycles high; st_fault and st_done pulse once; st_ready returns to 1.
- Reset mid-WR_HI with ack stalled: mem_req drops asynchronously, st_ready=1, no st_done. A following aligned store completes normally.
